// File: rtl/sync_frame_tx_if.sv
// Handshake and serial-line bundle for the sync frame transmitter.
// The master side requests frames; the slave side serialises them.
interface sync_frame_tx_if #(
   parameter int DATA_BITS = 8
);
   logic                 start;
   logic [DATA_BITS-1:0] data;
   logic                 ready;
   logic                 serial_out;
   logic                 frame_done;

   modport master (
      output start,
      output data,
      input  ready,
      input  serial_out,
      input  frame_done
   );

   modport slave (
      input  start,
      input  data,
      output ready,
      output serial_out,
      output frame_done
   );
endinterface

// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: 4-bit sync pattern, then payload LSB first.
// Feeds the '1101' detector input directly; returns to idle between frames.
module sync_frame_tx #(
   parameter int         DATA_BITS    = 8,
   parameter logic [3:0] SYNC_PATTERN = 4'b1101,
   parameter logic       IDLE_VALUE   = 1'b0
) (
   input logic             clk,
   input logic             n_rst,
   sync_frame_tx_if.slave  bus
);

   localparam int CB = $clog2(DATA_BITS) + 1;
   localparam int CW = (CB < 2) ? 2 : CB;

   // All-ones marks "last sync bit already driven"; DATA never reaches it.
   localparam logic [CW-1:0] SYNC_END = '1;
   localparam logic [CW-1:0] LAST     = CW'(DATA_BITS - 1);

   typedef enum logic [1:0] {
      IDLE,
      SYNC,
      DATA,
      DONE
   } state_t;

   state_t               state;
   state_t               state_n;
   logic [CW-1:0]        cnt;
   logic [CW-1:0]        cnt_n;
   logic [DATA_BITS-1:0] shift;
   logic [DATA_BITS-1:0] shift_n;
   logic                 so;
   logic                 so_n;
   logic                 done;
   logic                 done_n;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state <= IDLE;
         cnt   <= '0;
         shift <= '0;
         so    <= IDLE_VALUE;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         shift <= shift_n;
         so    <= so_n;
         done  <= done_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      shift_n = shift;
      so_n    = so;
      done_n  = 1'b0;
      unique case (state)
         IDLE: begin
            so_n = IDLE_VALUE;
            if (bus.start) begin
               shift_n = bus.data;
               state_n = SYNC;
               so_n    = SYNC_PATTERN[3];
               cnt_n   = CW'(2);
            end
         end
         SYNC: begin
            if (cnt == SYNC_END) begin
               state_n = DATA;
               so_n    = shift[0];
               shift_n = shift >> 1;
               cnt_n   = LAST;
            end else begin
               so_n  = SYNC_PATTERN[cnt[1:0]];
               cnt_n = cnt - 1'b1;
            end
         end
         DATA: begin
            if (cnt != '0) begin
               so_n    = shift[0];
               shift_n = shift >> 1;
               cnt_n   = cnt - 1'b1;
            end else begin
               state_n = DONE;
               so_n    = IDLE_VALUE;
               done_n  = 1'b1;
            end
         end
         DONE: begin
            state_n = IDLE;
            so_n    = IDLE_VALUE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.ready      = (state == IDLE);
   assign bus.serial_out = so;
   assign bus.frame_done = done;

endmodule

// File: tb/tb_sync_frame_tx.sv
// Scoreboard bench for sync_frame_tx: a frame-level model queues the
// expected per-cycle line state; a monitor pops and compares each cycle.
module tb_sync_frame_tx;

   localparam int         DB   = 8;
   localparam logic [3:0] SYNC = 4'b1101;

   typedef struct {
      logic so;
      logic done;
      logic rdy;
   } exp_t;

   logic clk;
   logic n_rst;

   sync_frame_tx_if #(.DATA_BITS(DB)) bus ();

   sync_frame_tx #(
      .DATA_BITS   (DB),
      .SYNC_PATTERN(SYNC),
      .IDLE_VALUE  (1'b0)
   ) dut (
      .clk  (clk),
      .n_rst(n_rst),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t exp_q[$];
   logic cur_ready;
   logic mon_en;
   int   vectors;
   int   miscompares;

   // Frame model: a whole frame is a list of line levels, computed
   // directly from the sync pattern and the payload word.
   task automatic model_step();
      exp_t e;
      if (exp_q.size() == 0) begin
         if (cur_ready && bus.start) begin
            for (int k = 0; k < 4; k++) begin
               e.so = SYNC[3-k]; e.done = 1'b0; e.rdy = 1'b0;
               exp_q.push_back(e);
            end
            for (int k = 0; k < DB; k++) begin
               e.so = bus.data[k]; e.done = 1'b0; e.rdy = 1'b0;
               exp_q.push_back(e);
            end
            e.so = 1'b0; e.done = 1'b1; e.rdy = 1'b0;
            exp_q.push_back(e);
            cur_ready = 1'b0;
         end else begin
            e.so = 1'b0; e.done = 1'b0; e.rdy = 1'b1;
            exp_q.push_back(e);
            cur_ready = 1'b1;
         end
      end
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (mon_en) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL underrun t=%0t: no expected entry", $time);
         end else begin
            e = exp_q.pop_front();
            if (bus.serial_out !== e.so || bus.frame_done !== e.done ||
                bus.ready !== e.rdy) begin
               miscompares++;
               $display("FAIL line t=%0t: got so=%b done=%b rdy=%b want so=%b done=%b rdy=%b",
                        $time, bus.serial_out, bus.frame_done, bus.ready,
                        e.so, e.done, e.rdy);
            end
         end
      end
   end

   task automatic check_reset(input string name);
      vectors++;
      if (bus.serial_out !== 1'b0 || bus.ready !== 1'b1 ||
          bus.frame_done !== 1'b0) begin
         miscompares++;
         $display("FAIL %s t=%0t: got so=%b rdy=%b done=%b want so=0 rdy=1 done=0",
                  name, $time, bus.serial_out, bus.ready, bus.frame_done);
      end
   endtask

   task automatic cycle(input logic st, input logic [DB-1:0] d);
      @(negedge clk);
      bus.start = st;
      bus.data  = d;
      model_step();
   endtask

   // Reset asserted between edges, so only the asynchronous path clears it.
   task automatic do_reset();
      @(negedge clk);
      #2;
      mon_en = 1'b0;
      n_rst  = 1'b0;
      bus.start = 1'b1;
      bus.data  = 8'hFF;
      #1;
      check_reset("async_reset");
      repeat (2) begin
         @(posedge clk);
         #1;
         check_reset("in_reset");
      end
      exp_q.delete();
      cur_ready = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      n_rst = 1'b1;
      model_step();
      mon_en = 1'b1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      mon_en      = 1'b0;
      cur_ready   = 1'b1;
      n_rst       = 1'b0;
      bus.start   = 1'b1;
      bus.data    = 8'hFF;
      #1;
      check_reset("por");
      repeat (2) begin
         @(posedge clk);
         #1;
         check_reset("por_hold");
      end
      @(negedge clk);
      bus.start = 1'b0;
      n_rst = 1'b1;
      model_step();
      mon_en = 1'b1;
      repeat (3) cycle(1'b0, 8'hFF);

      cycle(1'b1, 8'hA5);
      repeat (16) cycle(1'b0, 8'h00);

      cycle(1'b1, 8'h0F);
      repeat (5) cycle(1'b0, 8'h0F);
      repeat (3) cycle(1'b1, 8'hFF);
      repeat (8) cycle(1'b0, 8'h00);

      repeat (44) cycle(1'b1, 8'h3C);
      repeat (16) cycle(1'b0, 8'h00);

      cycle(1'b1, 8'hC3);
      repeat (6) cycle(1'b0, 8'h00);
      do_reset();
      cycle(1'b1, 8'h01);
      repeat (16) cycle(1'b0, 8'h00);

      for (int i = 0; i < 400; i++) begin
         if (i == 200) do_reset();
         cycle(($urandom_range(0, 3) == 0), DB'($urandom));
      end
      repeat (16) cycle(1'b0, 8'h00);
      @(posedge clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
